// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester, ALU and response buses of the shared-ALU arbiter.
// The arbiter uses the slave modport; clients, ALU and testbench use the master modport.
interface alu_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int CMD_WIDTH = 4,
    parameter int IDW = 2
);
    logic [NREQ-1:0] req_valid, req_ready, req_mode, req_cin;
    logic [NREQ*WIDTH-1:0] req_opa, req_opb;
    logic [NREQ*CMD_WIDTH-1:0] req_cmd;
    logic [NREQ*2-1:0] req_inp_valid;
    logic [WIDTH-1:0] alu_opa, alu_opb;
    logic [CMD_WIDTH-1:0] alu_cmd;
    logic alu_mode, alu_cin, alu_ce;
    logic [1:0] alu_inp_valid;
    logic [2*WIDTH-1:0] alu_res;
    logic [5:0] alu_flags;
    logic rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [2*WIDTH-1:0] rsp_res;
    logic [5:0] rsp_flags;
    logic busy;
    modport slave (
        input req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, alu_res, alu_flags,
        output req_ready, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid, alu_ce,
        output rsp_valid, rsp_id, rsp_res, rsp_flags, busy
    );
    modport master (
        output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, alu_res, alu_flags,
        input req_ready, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid, alu_ce,
        input rsp_valid, rsp_id, rsp_res, rsp_flags, busy
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one registered ALU among NREQ requesters, tagged responses.
// Define ALU_ARB_PRIO0_EN to make requester 0 strict high priority over a round-robin of the rest.
module alu_req_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int CMD_WIDTH = 4,
    parameter int IDW = 2
) (
    input logic clk,
    input logic rst,
    alu_req_arbiter_if.slave bus
);
    logic [IDW-1:0] ptr, gnt_id;
    logic gnt, blk, is_mult, done_n, done_m;
    logic [2:0] pv, pm;
    logic [IDW-1:0] pid [3];

    // A mult grant sitting in stage 0 forces a bubble so completions never share an edge
    assign blk = pv[0] & pm[0];
    assign done_n = pv[1] & ~pm[1];
    assign done_m = pv[2] & pm[2];
    assign is_mult = bus.alu_mode && (bus.alu_cmd == CMD_WIDTH'(9) || bus.alu_cmd == CMD_WIDTH'(10));
    assign bus.alu_ce = gnt;
    assign bus.busy = |pv;

    always_comb begin
        int j;
        j = 0;
        gnt_id = '0;
        gnt = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            j = (int'(ptr) + i) % NREQ;
`ifdef ALU_ARB_PRIO0_EN
            if (j != 0 && bus.req_valid[IDW'(j)]) begin
`else
            if (bus.req_valid[IDW'(j)]) begin
`endif
                gnt = 1'b1;
                gnt_id = IDW'(j);
            end
        end
`ifdef ALU_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            gnt = 1'b1;
            gnt_id = '0;
        end
`endif
        if (blk || rst) gnt = 1'b0;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.alu_opa = '0;
        bus.alu_opb = '0;
        bus.alu_cmd = '0;
        bus.alu_mode = 1'b0;
        bus.alu_cin = 1'b0;
        bus.alu_inp_valid = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt && gnt_id == IDW'(i)) begin
                bus.req_ready[i] = 1'b1;
                bus.alu_opa = bus.req_opa[i*WIDTH +: WIDTH];
                bus.alu_opb = bus.req_opb[i*WIDTH +: WIDTH];
                bus.alu_cmd = bus.req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
                bus.alu_mode = bus.req_mode[i];
                bus.alu_cin = bus.req_cin[i];
                bus.alu_inp_valid = bus.req_inp_valid[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
            pv <= '0;
            pm <= '0;
            pid <= '{default: '0};
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_res <= '0;
            bus.rsp_flags <= '0;
        end else begin
            pv <= {pv[1:0], gnt};
            pm <= {pm[1:0], is_mult};
            pid[0] <= gnt_id;
            pid[1] <= pid[0];
            pid[2] <= pid[1];
`ifdef ALU_ARB_PRIO0_EN
            if (gnt && gnt_id != '0) ptr <= gnt_id;
`else
            if (gnt) ptr <= gnt_id;
`endif
            bus.rsp_valid <= done_n | done_m;
            if (done_n | done_m) begin
                bus.rsp_id <= done_m ? pid[2] : pid[1];
                bus.rsp_res <= bus.alu_res;
                bus.rsp_flags <= bus.alu_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed checks of arbitration order, latency, mult bubble, ERR and reset.
// Includes a small ALU model: 2-edge latency normal ops, 3-edge for mult (cmd 9/10 in arithmetic mode).
module tb_alu_req_arbiter;
    logic clk, rst;
    int checks = 0, failures = 0;
    localparam bit PRIO0 =
`ifdef ALU_ARB_PRIO0_EN
        1'b1;
`else
        1'b0;
`endif

    alu_req_arbiter_if #(.NREQ(4), .WIDTH(8), .CMD_WIDTH(4), .IDW(2)) bus ();
    alu_req_arbiter #(.NREQ(4), .WIDTH(8), .CMD_WIDTH(4), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic m);
        if (m) begin
            case (c)
                4'd0: return {6'h00, 16'(a) + 16'(b)};
                4'd9: return {6'h00, (16'(a) + 16'd1) * (16'(b) + 16'd1)};
                4'd10: return {6'h00, (16'(a) << 1) * 16'(b)};
                default: return {6'h20, 16'h0000};
            endcase
        end
        case (c)
            4'd0: return {6'h00, 8'h00, a & b};
            4'd1: return {6'h00, 8'h00, a | b};
            default: return {6'h20, 16'h0000};
        endcase
    endfunction

    logic [21:0] p1, p2;
    logic p1v, p1m, p2v;
    always @(posedge clk) begin
        p1 <= bus.alu_ce ? alu_f(bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode) : 22'h0;
        p1v <= bus.alu_ce;
        p1m <= bus.alu_ce && bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10);
        p2 <= p1;
        p2v <= p1v & p1m;
        if (p1v && !p1m) {bus.alu_flags, bus.alu_res} <= p1;
        else if (p2v) {bus.alu_flags, bus.alu_res} <= p2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic m);
        bus.req_opa[i*8 +: 8] = a;
        bus.req_opb[i*8 +: 8] = b;
        bus.req_cmd[i*4 +: 4] = c;
        bus.req_mode[i] = m;
        bus.req_cin[i] = 1'b0;
        bus.req_inp_valid[i*2 +: 2] = 2'b11;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_opa = '0;
        bus.req_opb = '0;
        bus.req_cmd = '0;
        bus.req_mode = '0;
        bus.req_cin = '0;
        bus.req_inp_valid = '0;
        do_reset();
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_ce", bus.alu_ce, 0);
        chk("rst_rv", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res", bus.rsp_res, 0);
        // single ADD, 2-edge latency
        set_req(0, 8'h05, 8'h03, 4'd0, 1'b1);
        #1;
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_opa", bus.alu_opa, 8'h05);
        chk("t1_iv", bus.alu_inp_valid, 2'b11);
        step();
        bus.req_valid = '0;
        #1;
        chk("t1_busy", bus.busy, 1);
        chk("t1_rv0", bus.rsp_valid, 0);
        step();
        chk("t1_rv1", bus.rsp_valid, 0);
        step();
        chk("t1_rv", bus.rsp_valid, 1);
        chk("t1_id", bus.rsp_id, 0);
        chk("t1_res", bus.rsp_res, 16'h0008);
        chk("t1_flags", bus.rsp_flags, 6'h00);
        step();
        chk("t1_pulse", bus.rsp_valid, 0);
        // all four requesters issuing AND continuously
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'hFF, 8'(i + 1), 4'd0, 1'b0);
        for (int n = 0; n < 7; n++) begin
            #1;
            if (n < 5) chk("t2_gnt", bus.req_ready, 32'(1) << (PRIO0 ? 0 : n % 4));
            else chk("t2_idle", bus.req_ready, 0);
            step();
            if (n == 4) bus.req_valid = '0;
            if (n >= 2) begin
                chk("t2_rv", bus.rsp_valid, 1);
                chk("t2_id", bus.rsp_id, PRIO0 ? 0 : (n - 2) % 4);
                chk("t2_res", bus.rsp_res, PRIO0 ? 1 : (n - 2) % 4 + 1);
            end
        end
        // mult then add: bubble, then ordered completions
        do_reset();
        set_req(1, 8'h02, 8'h03, 4'd9, 1'b1);
        set_req(2, 8'h04, 8'h01, 4'd0, 1'b1);
        #1;
        chk("t3_gnt1", bus.req_ready, 4'b0010);
        step();
        bus.req_valid[1] = 1'b0;
        #1;
        chk("t3_bubble", bus.req_ready, 0);
        chk("t3_bubce", bus.alu_ce, 0);
        step();
        chk("t3_gnt2", bus.req_ready, 4'b0100);
        step();
        bus.req_valid[2] = 1'b0;
        chk("t3_rv_early", bus.rsp_valid, 0);
        step();
        chk("t3_rv1", bus.rsp_valid, 1);
        chk("t3_id1", bus.rsp_id, 1);
        chk("t3_res1", bus.rsp_res, 16'h000C);
        step();
        chk("t3_rv2", bus.rsp_valid, 1);
        chk("t3_id2", bus.rsp_id, 2);
        chk("t3_res2", bus.rsp_res, 16'h0005);
        step();
        chk("t3_end", bus.rsp_valid, 0);
        // illegal command: ERR passes through
        do_reset();
        set_req(3, 8'h07, 8'h07, 4'hF, 1'b1);
        #1;
        chk("t4_gnt", bus.req_ready, 4'b1000);
        step();
        bus.req_valid = '0;
        step();
        step();
        chk("t4_rv", bus.rsp_valid, 1);
        chk("t4_id", bus.rsp_id, 3);
        chk("t4_flags", bus.rsp_flags, 6'h20);
        chk("t4_res", bus.rsp_res, 0);
        // reset with ops in flight
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'h0F, 8'h0F, 4'd1, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_rv", bus.rsp_valid, 0);
        chk("t5_ready", bus.req_ready, 0);
        chk("t5_ce", bus.alu_ce, 0);
        bus.req_valid = '0;
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t5_norsp", bus.rsp_valid, 0);
        end
        // requester 0 and 2 both valid continuously
        do_reset();
        set_req(0, 8'h01, 8'h01, 4'd0, 1'b1);
        set_req(2, 8'h02, 8'h02, 4'd0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("t6_gnt", bus.req_ready, PRIO0 ? 1 : (n % 2 == 1 ? 4 : 1));
            step();
        end
        bus.req_valid = '0;
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
